gpio_input_conditioner: RTL and testbench

// - Conditions raw board inputs (KEY[3:0], SW[9:0]) before they reach the PIO_IN export of the SoC.
// - Per bit: synchronizer, counter debounce, change pulse, optional sticky rising-edge flag.
// - Output word drives the 32-bit PIO_IN export directly; firmware polls it over the system bus.

---
 rtl/gpio_cond_pkg.sv | 19 +
 rtl/gpio_debounce_bit.sv | 67 ++++++
 rtl/gpio_input_conditioner.sv | 82 ++++++++
 tb/tb_gpio_input_conditioner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
// Imported by gpio_debounce_bit and gpio_input_conditioner.
package gpio_cond_pkg;

  localparam int GPIO_WORD_W = 32;
  localparam int MAX_IN = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int LEVEL_LSB = 0;

  function automatic int cnt_width(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int flag_lsb(input int n_in);
    return LEVEL_LSB + n_in;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input bit: synchronizer chain, counter debounce,
// debounced level and one-cycle change pulse.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset_p,
  input  logic raw_i,
  output logic level_o,
  output logic change_o,
  output logic rise_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_change;

  logic w_s;
  logic w_diff;
  logic w_term;
  logic w_commit;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_diff   = w_s ^ r_level;
  assign w_term   = (r_cnt == TERM);
  assign w_commit = w_diff & w_term;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_sync <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Any return to the held level restarts the wait from zero.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_cnt    <= '0;
      r_level  <= RESET_BIT;
      r_change <= 1'b0;
    end else begin
      r_change <= w_commit;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_term) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level_o  = r_level;
  assign change_o = r_change;
  assign rise_o   = w_commit & w_s;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions {SW, KEY} board inputs into the 32-bit PIO_IN word.
// Sticky rising-edge flags exist only when GPIO_EDGE_LATCH_EN is defined.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int              N_IN            = 14,
  parameter int              SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [N_IN-1:0] RESET_VAL       = 14'h000F
) (
  input  logic                   clk,
  input  logic                   reset_p,
  input  logic [N_IN-1:0]        raw_i,
  input  logic [N_IN-1:0]        clr_i,
  output logic [N_IN-1:0]        level_o,
  output logic [N_IN-1:0]        change_o,
  output logic [GPIO_WORD_W-1:0] gpio_word_o
);

  localparam int FLAG_LSB = flag_lsb(N_IN);

  if (N_IN < 1 || N_IN > MAX_IN) begin : g_bad_n_in
    $error("N_IN out of range 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [N_IN-1:0] w_level;
  logic [N_IN-1:0] w_change;
  logic [N_IN-1:0] w_rise;
  logic [N_IN-1:0] w_flag;
  logic [GPIO_WORD_W-1:0] w_word;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VAL[gi])
    ) u_bit (
      .clk      (clk),
      .reset_p  (reset_p),
      .raw_i    (raw_i[gi]),
      .level_o  (w_level[gi]),
      .change_o (w_change[gi]),
      .rise_o   (w_rise[gi])
    );
  end

`ifdef GPIO_EDGE_LATCH_EN
  logic [N_IN-1:0] r_flag;

  // Set has priority so a rise coinciding with a clear is never lost.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_flag <= '0;
    end else begin
      r_flag <= w_rise | (r_flag & ~clr_i);
    end
  end

  assign w_flag = r_flag;
`else
  logic w_unused_in;
  assign w_unused_in = ^{clr_i, w_rise};
  assign w_flag = '0;
`endif

  always_comb begin
    w_word = '0;
    w_word[LEVEL_LSB +: N_IN] = w_level;
    w_word[FLAG_LSB +: N_IN]  = w_flag;
  end

  assign level_o     = w_level;
  assign change_o    = w_change;
  assign gpio_word_o = w_word;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed table-driven bench for gpio_input_conditioner.
// Expected flag bits are masked when GPIO_EDGE_LATCH_EN is undefined.
module tb_gpio_input_conditioner;

  logic        clk;
  logic        reset_p;
  logic [13:0] raw_i;
  logic [13:0] clr_i;
  logic [13:0] level_o;
  logic [13:0] change_o;
  logic [31:0] gpio_word_o;

  int total = 0;
  int bad = 0;

  gpio_input_conditioner #(
    .N_IN            (14),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .RESET_VAL       (14'h000F)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .raw_i       (raw_i),
    .clr_i       (clr_i),
    .level_o     (level_o),
    .change_o    (change_o),
    .gpio_word_o (gpio_word_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] raw;
    logic [13:0] clr;
    int          n;
    logic [13:0] lvl;
    logic [13:0] chg;
    logic [13:0] flg;
  } vec_t;

  vec_t tv[8];

  function automatic logic [31:0] xword(input logic [13:0] l,
                                        input logic [13:0] f);
`ifdef GPIO_EDGE_LATCH_EN
    return {4'h0, f, l};
`else
    return {18'h0, l} | ({18'h0, f} & 32'h0);
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
`ifndef GPIO_EDGE_LATCH_EN
    check("hi_zero", {14'h0, gpio_word_o[31:14]}, 32'h0);
`endif
  endtask

  task automatic do_reset();
    raw_i = 14'h000F;
    clr_i = '0;
    reset_p = 1'b1;
    tick();
    tick();
    reset_p = 1'b0;
    tick();
  endtask

  initial begin
    logic [13:0] acc;

    tv[0] = '{14'h001F, 14'h0000, 9,  14'h000F, 14'h0000, 14'h0000};
    tv[1] = '{14'h001F, 14'h0000, 1,  14'h001F, 14'h0010, 14'h0010};
    tv[2] = '{14'h001F, 14'h0000, 1,  14'h001F, 14'h0000, 14'h0010};
    tv[3] = '{14'h001F, 14'h0010, 1,  14'h001F, 14'h0000, 14'h0000};
    tv[4] = '{14'h000F, 14'h0000, 10, 14'h000F, 14'h0010, 14'h0000};
    tv[5] = '{14'h000F, 14'h0000, 3,  14'h000F, 14'h0000, 14'h0000};
    tv[6] = '{14'h008F, 14'h0000, 5,  14'h000F, 14'h0000, 14'h0000};
    tv[7] = '{14'h000F, 14'h0000, 20, 14'h000F, 14'h0000, 14'h0000};

    // reset state
    raw_i = 14'h000F;
    clr_i = '0;
    reset_p = 1'b1;
    #2;
    check("rst_level", {18'h0, level_o}, 32'h000F);
    check("rst_change", {18'h0, change_o}, 32'h0);
    check("rst_word", gpio_word_o, 32'h0000_000F);
    tick();
    tick();
    reset_p = 1'b0;

    acc = '0;
    for (int k = 0; k < 50; k++) begin
      tick();
      acc |= change_o;
    end
    check("idle_change", {18'h0, acc}, 32'h0);
    check("idle_level", {18'h0, level_o}, 32'h000F);

    // table
    for (int v = 0; v < 8; v++) begin
      raw_i = tv[v].raw;
      clr_i = tv[v].clr;
      for (int k = 0; k < tv[v].n; k++) tick();
      check($sformatf("tv%0d_level", v), {18'h0, level_o},
            {18'h0, tv[v].lvl});
      check($sformatf("tv%0d_change", v), {18'h0, change_o},
            {18'h0, tv[v].chg});
      check($sformatf("tv%0d_word", v), gpio_word_o,
            xword(tv[v].lvl, tv[v].flg));
    end
    clr_i = '0;

    // bounce on bit 0
    do_reset();
    acc = '0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) raw_i[0] = ~raw_i[0];
      tick();
      acc |= ~level_o & 14'h0001;
    end
    check("bnc_hold", {18'h0, acc}, 32'h0);
    raw_i[0] = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check("bnc_pre", {31'h0, level_o[0]}, 32'h1);
    tick();
    check("bnc_fall", {18'h0, level_o}, 32'h000E);
    check("bnc_chg", {18'h0, change_o}, 32'h0001);
    check("bnc_word", gpio_word_o, xword(14'h000E, 14'h0));

    // clear coinciding with set on bit 5
    do_reset();
    raw_i = 14'h002F;
    for (int k = 0; k < 9; k++) tick();
    clr_i = 14'h0020;
    tick();
    clr_i = '0;
    check("cs_level", {18'h0, level_o}, 32'h002F);
    check("cs_chg", {18'h0, change_o}, 32'h0020);
    check("cs_word", gpio_word_o, xword(14'h002F, 14'h0020));
    tick();
    check("cs_hold", gpio_word_o, xword(14'h002F, 14'h0020));
    clr_i = 14'h0020;
    tick();
    clr_i = '0;
    check("cs_clr", gpio_word_o, xword(14'h002F, 14'h0000));

    // multi-bit simultaneous
    do_reset();
    raw_i = 14'h3FF0;
    for (int k = 0; k < 9; k++) tick();
    check("mb_pre", {18'h0, level_o}, 32'h000F);
    tick();
    check("mb_level", {18'h0, level_o}, 32'h3FF0);
    check("mb_chg", {18'h0, change_o}, 32'h3FFF);
    check("mb_word", gpio_word_o, xword(14'h3FF0, 14'h3FF0));
    tick();
    check("mb_chg_end", {18'h0, change_o}, 32'h0);

    // reset mid-debounce on bit 9
    do_reset();
    raw_i = 14'h020F;
    for (int k = 0; k < 5; k++) tick();
    reset_p = 1'b1;
    tick();
    check("rm_level", {18'h0, level_o}, 32'h000F);
    check("rm_word", gpio_word_o, 32'h0000_000F);
    reset_p = 1'b0;
    acc = '0;
    for (int k = 0; k < 9; k++) begin
      tick();
      acc |= change_o | level_o[9] << 9;
    end
    check("rm_quiet", {18'h0, acc}, 32'h0);
    tick();
    check("rm_level_up", {18'h0, level_o}, 32'h020F);
    check("rm_chg", {18'h0, change_o}, 32'h0200);
    check("rm_word", gpio_word_o, xword(14'h020F, 14'h0200));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
